// File: rtl/race_outcome_monitor.sv
// Race outcome monitor: synchronises two event lines, decides which rose first
// (or a tie / timeout) per armed trial, and keeps saturating outcome counters.
module race_outcome_monitor #(
    parameter int unsigned LAT_W   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit0,
    input  logic             bit1,
    input  logic             clr_counts,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_winner,
    output logic [LAT_W-1:0] res_latency,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt_tie,
    output logic [CNT_W-1:0] cnt_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync0_q, sync1_q;
    logic             prev0_q, prev1_q;
    logic             rise0_q, rise1_q;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [1:0]       win_q, win_d;
    logic [LAT_W-1:0] rlat_q, rlat_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             done;
    logic [CNT_W-1:0] cnt0_q, cnt1_q, cnt_tie_q, cnt_to_q;
    logic [CNT_W-1:0] cnt0_d, cnt1_d, cnt_tie_d, cnt_to_d;

    // Edge detectors run in every state; the rise flag is registered so an
    // input edge before clock N is seen in the cycle after edge N+2.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
            prev0_q <= 1'b0;
            prev1_q <= 1'b0;
            rise0_q <= 1'b0;
            rise1_q <= 1'b0;
        end else begin
            sync0_q <= {sync0_q[0], bit0};
            sync1_q <= {sync1_q[0], bit1};
            prev0_q <= sync0_q[1];
            prev1_q <= sync1_q[1];
            rise0_q <= sync0_q[1] & ~prev0_q;
            rise1_q <= sync1_q[1] & ~prev1_q;
        end
    end

    // State register and result/latency datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
            win_q   <= '0;
            rlat_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            win_q   <= win_d;
            rlat_q  <= rlat_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        win_d   = win_q;
        rlat_d  = rlat_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    lat_d   = '0;
                end
            end
            ARMED: begin
                // An event on the timeout cycle takes precedence over the timeout.
                if (rise0_q || rise1_q || (lat_q == LAT_W'(TIMEOUT))) begin
                    done    = 1'b1;
                    win_d   = {rise1_q, rise0_q};
                    rlat_d  = lat_q;
                    state_d = RESULT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: registered status flags and outcome counter updates
    always_comb begin
        busy_d    = (state_d != IDLE);
        valid_d   = (state_d == RESULT);
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        cnt_tie_d = cnt_tie_q;
        cnt_to_d  = cnt_to_q;
        if (clr_counts) begin
            cnt0_d    = '0;
            cnt1_d    = '0;
            cnt_tie_d = '0;
            cnt_to_d  = '0;
        end else if (done) begin
            unique case (win_d)
                2'b01:   if (cnt0_q != '1)    cnt0_d    = cnt0_q + 1'b1;
                2'b10:   if (cnt1_q != '1)    cnt1_d    = cnt1_q + 1'b1;
                2'b11:   if (cnt_tie_q != '1) cnt_tie_d = cnt_tie_q + 1'b1;
                default: if (cnt_to_q != '1)  cnt_to_d  = cnt_to_q + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            cnt_tie_q <= '0;
            cnt_to_q  <= '0;
        end else begin
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            cnt_tie_q <= cnt_tie_d;
            cnt_to_q  <= cnt_to_d;
        end
    end

    assign busy        = busy_q;
    assign res_valid   = valid_q;
    assign res_winner  = win_q;
    assign res_latency = rlat_q;
    assign cnt0        = cnt0_q;
    assign cnt1        = cnt1_q;
    assign cnt_tie     = cnt_tie_q;
    assign cnt_timeout = cnt_to_q;

endmodule
